bp_lce_resp_arb_credits: RTL and testbench

Parametrised LCE response arbiter and outstanding-request credit tracker for any LCE (dcache, icache, or multi-engine LCE). It merges `num_src_p` response sources onto one LCE→CCE response channel using fixed priority, with optional anti-starvation. It also counts in-flight LCE requests against a configurable credit limit. Multiple credit returns may arrive in the same cycle.

---
 rtl/bp_lce_resp_arb_credits.sv | 116 +++++++++++
 tb/tb_bp_lce_resp_arb_credits.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bp_lce_resp_arb_credits.sv
// LCE response arbiter (fixed priority, index 0 highest) with an outstanding-request credit counter.
// Define BP_LCE_RESP_STARVE_GUARD_EN to promote sources that have waited starve_limit_p cycles.
module bp_lce_resp_arb_credits #(
  parameter int num_src_p      = 2,
  parameter int resp_width_p   = 64,
  parameter int max_credits_p  = 8,
  parameter int num_ret_p      = 4,
  parameter int starve_limit_p = 16
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [num_src_p*resp_width_p-1:0]       src_resp_i,
  input  logic [num_src_p-1:0]                    src_v_i,
  output logic [num_src_p-1:0]                    src_yumi_o,
  output logic [resp_width_p-1:0]                 resp_o,
  output logic                                    resp_v_o,
  input  logic                                    resp_ready_i,
  input  logic                                    req_v_i,
  input  logic                                    req_ready_i,
  input  logic [num_ret_p-1:0]                    ret_v_i,
  output logic [$clog2(max_credits_p+1)-1:0]      credit_count_o,
  output logic                                    credits_full_o,
  output logic                                    credits_empty_o,
  output logic                                    credit_err_o
);

  localparam int cw_lp = $clog2(max_credits_p+1);
  localparam int nw_lp = cw_lp + $clog2(num_ret_p+1);
  localparam logic signed [nw_lp-1:0] max_s_lp = nw_lp'(max_credits_p);

  logic [num_src_p-1:0] promoted;
  logic [num_src_p-1:0] pick;

  // Promotion overrides the normal order; the lowest-index promoted source wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pick = '0;
    for (int i = num_src_p-1; i >= 0; i--) begin
      if (src_v_i[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    if (|promoted) begin
      pick = '0;
      for (int i = num_src_p-1; i >= 0; i--) begin
        if (promoted[i]) begin
          pick    = '0;
          pick[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    resp_o = '0;
    for (int i = 0; i < num_src_p; i++) begin
      if (pick[i]) resp_o = resp_o | src_resp_i[i*resp_width_p +: resp_width_p];
    end
  end

  assign resp_v_o   = |src_v_i;
  assign src_yumi_o = pick & {num_src_p{resp_ready_i & resp_v_o}};

`ifdef BP_LCE_RESP_STARVE_GUARD_EN
  localparam int sw_lp = $clog2(starve_limit_p+1);
  assign promoted[0] = 1'b0;
  for (genvar i = 1; i < num_src_p; i++) begin : g_starve
    logic [sw_lp-1:0] wait_cnt;
    always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset_i)                          wait_cnt <= '0;
      else if (!src_v_i[i] || src_yumi_o[i]) wait_cnt <= '0;
      else if (wait_cnt != sw_lp'(starve_limit_p)) wait_cnt <= wait_cnt + 1'b1;
    end
    // Masked with valid so a source that dropped out is never granted.
    assign promoted[i] = src_v_i[i] && (wait_cnt == sw_lp'(starve_limit_p));
  end
`else
  assign promoted = '0;
`endif

  logic [cw_lp-1:0]        count_r;
  logic                    err_r;
  logic [nw_lp-1:0]        ret_pop;
  logic signed [nw_lp-1:0] next_s;

  always_comb begin
    ret_pop = '0;
    for (int i = 0; i < num_ret_p; i++) ret_pop = ret_pop + nw_lp'(ret_v_i[i]);
  end

  assign next_s = $signed(nw_lp'(count_r)) + $signed(nw_lp'(req_v_i & req_ready_i))
                - $signed(ret_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
      err_r   <= 1'b0;
    end else if (next_s[nw_lp-1]) begin
      count_r <= '0;
      err_r   <= 1'b1;
    end else if (next_s > max_s_lp) begin
      count_r <= cw_lp'(max_credits_p);
      err_r   <= 1'b1;
    end else begin
      count_r <= next_s[cw_lp-1:0];
    end
  end

  assign credit_count_o  = count_r;
  assign credits_full_o  = (count_r == cw_lp'(max_credits_p));
  assign credits_empty_o = (count_r == '0);
  assign credit_err_o    = err_r;

endmodule

// File: tb/tb_bp_lce_resp_arb_credits.sv
// Scoreboard bench for bp_lce_resp_arb_credits; starvation expectations follow BP_LCE_RESP_STARVE_GUARD_EN.
module tb_bp_lce_resp_arb_credits;

  localparam int W      = 64;
  localparam int STARVE = 4;
`ifdef BP_LCE_RESP_STARVE_GUARD_EN
  localparam bit guard_on = 1'b1;
`else
  localparam bit guard_on = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic [2*W-1:0] src_resp;
  logic [1:0]    src_v, src_yumi;
  logic [W-1:0]  resp;
  logic          resp_v, resp_ready;
  logic          req_v, req_ready;
  logic [3:0]    ret_v;
  logic [3:0]    credit_count;
  logic          full, empty, err;

  bp_lce_resp_arb_credits #(
    .num_src_p(2), .resp_width_p(W), .max_credits_p(8), .num_ret_p(4), .starve_limit_p(STARVE)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .src_resp_i(src_resp), .src_v_i(src_v),
    .src_yumi_o(src_yumi), .resp_o(resp), .resp_v_o(resp_v), .resp_ready_i(resp_ready),
    .req_v_i(req_v), .req_ready_i(req_ready), .ret_v_i(ret_v),
    .credit_count_o(credit_count), .credits_full_o(full), .credits_empty_o(empty),
    .credit_err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [1:0] yumi; logic [W-1:0] resp; logic v; } arb_exp_t;
  typedef struct { string tag; logic [3:0] count; logic full; logic empty; logic err; } cred_exp_t;
  arb_exp_t  arb_q[$];
  cred_exp_t cred_q[$];

  int checks = 0;
  int errors = 0;
  int m_count = 0;
  bit m_err   = 1'b0;
  int m_wait1 = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_arb();
    arb_exp_t e;
    if (arb_q.size() == 0) begin
      check("arb_sb_empty", 1, 0);
      return;
    end
    e = arb_q.pop_front();
    check({e.tag, "_v"}, resp_v, e.v);
    check({e.tag, "_yumi"}, src_yumi, e.yumi);
    check({e.tag, "_resp"}, resp, e.resp);
  endtask

  task automatic pop_cred();
    cred_exp_t e;
    if (cred_q.size() == 0) begin
      check("cred_sb_empty", 1, 0);
      return;
    end
    e = cred_q.pop_front();
    check({e.tag, "_count"}, credit_count, e.count);
    check({e.tag, "_full"}, full, e.full);
    check({e.tag, "_empty"}, empty, e.empty);
    check({e.tag, "_err"}, err, e.err);
  endtask

  function automatic arb_exp_t arb_model(input string tag, input logic [1:0] v, input logic rdy,
                                         input logic [W-1:0] p0, input logic [W-1:0] p1);
    arb_exp_t  e;
    logic [1:0] g;
    if (guard_on && v[1] && m_wait1 == STARVE) g = 2'b10;
    else if (v[0])                             g = 2'b01;
    else if (v[1])                             g = 2'b10;
    else                                       g = 2'b00;
    e.tag  = tag;
    e.v    = |v;
    e.yumi = (rdy && |v) ? g : 2'b00;
    e.resp = g[0] ? p0 : (g[1] ? p1 : '0);
    return e;
  endfunction

  // Starts and ends 1-2 time units after a rising edge; spans one clock.
  task automatic arb_step(input string tag, input logic [1:0] v, input logic rdy,
                          input logic [W-1:0] p0, input logic [W-1:0] p1);
    arb_exp_t e;
    src_v = v; resp_ready = rdy; src_resp = {p1, p0};
    e = arb_model(tag, v, rdy, p0, p1);
    arb_q.push_back(e);
    #1;
    pop_arb();
    if (!v[1] || e.yumi[1]) m_wait1 = 0;
    else if (m_wait1 < STARVE) m_wait1++;
    @(posedge clk); #1;
  endtask

  function automatic cred_exp_t cred_push(input string tag);
    cred_exp_t e;
    e.tag = tag; e.count = 4'(m_count); e.full = (m_count == 8);
    e.empty = (m_count == 0); e.err = m_err;
    return e;
  endfunction

  task automatic cred_step(input string tag, input logic rq, input logic rr, input logic [3:0] rt);
    int nxt;
    req_v = rq; req_ready = rr; ret_v = rt;
    nxt = m_count + int'(rq & rr) - $countones(rt);
    if (nxt > 8)      begin m_count = 8; m_err = 1'b1; end
    else if (nxt < 0) begin m_count = 0; m_err = 1'b1; end
    else              m_count = nxt;
    cred_q.push_back(cred_push(tag));
    @(posedge clk); #1;
    pop_cred();
    req_v = 1'b0; req_ready = 1'b0; ret_v = '0;
  endtask

  // Arbiter stays combinational during reset; counter ignores that cycle's traffic.
  task automatic do_reset(input string tag);
    reset_i = 1'b1; src_v = 2'b01; resp_ready = 1'b1; src_resp = {64'h1111, 64'h2222};
    req_v = 1'b1; req_ready = 1'b1; ret_v = 4'b0011;
    arb_q.push_back(arb_model({tag, "_arb"}, 2'b01, 1'b1, 64'h2222, 64'h1111));
    #1;
    pop_arb();
    m_count = 0; m_err = 1'b0; m_wait1 = 0;
    cred_q.push_back(cred_push(tag));
    @(posedge clk); #1;
    pop_cred();
    reset_i = 1'b0; req_v = 1'b0; req_ready = 1'b0; ret_v = '0; src_v = '0; resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; src_v = '0; resp_ready = 1'b0; src_resp = '0;
    req_v = 1'b0; req_ready = 1'b0; ret_v = '0;
    @(posedge clk); #1;
    do_reset("reset0");

    arb_step("prio11", 2'b11, 1'b1, 64'hA0A0_0000_0000_0001, 64'hB1B1_0000_0000_0002);
    arb_step("prio10", 2'b10, 1'b1, 64'hA0A0_0000_0000_0003, 64'hB1B1_0000_0000_0004);
    arb_step("idle",   2'b00, 1'b1, 64'hDEAD, 64'hBEEF);
    for (int i = 0; i < 5; i++)
      arb_step($sformatf("bp%0d", i), 2'b01, 1'b0, 64'hC0FF_EE00_1234_5678, 64'h0);
    arb_step("bp_both", 2'b11, 1'b0, 64'h55, 64'h66);
    arb_step("idle2",   2'b00, 1'b0, 64'h0, 64'h0);

    for (int i = 0; i < 8; i++) cred_step($sformatf("fill%0d", i), 1'b1, 1'b1, 4'b0000);
    cred_step("full_net",   1'b1, 1'b1, 4'b0001);
    cred_step("no_hshk",    1'b1, 1'b0, 4'b0000);
    cred_step("overflow",   1'b1, 1'b1, 4'b0000);

    do_reset("reset1");
    for (int i = 0; i < 5; i++) cred_step($sformatf("to5_%0d", i), 1'b1, 1'b1, 4'b0000);
    cred_step("multi_ret",  1'b1, 1'b1, 4'b1011);
    cred_step("underflow",  1'b0, 1'b0, 4'b1111);
    for (int i = 0; i < 6; i++) cred_step($sformatf("to6_%0d", i), 1'b1, 1'b1, 4'b0000);
    do_reset("reset_mid");

    for (int i = 0; i < 12; i++)
      arb_step($sformatf("starve%0d", i), 2'b11, 1'b1, 64'(i) | 64'hA000, 64'(i) | 64'hB000);
    arb_step("drop1", 2'b01, 1'b1, 64'h1, 64'h2);
    for (int i = 0; i < 6; i++)
      arb_step($sformatf("restarve%0d", i), 2'b11, 1'b1, 64'(i) | 64'hC000, 64'(i) | 64'hD000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
